// File: rtl/run_monitor_if.sv
// Signal bundle between a CPU test harness and run_monitor:
// snooped data-memory writes, expected-table loads and run results.
interface run_monitor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  halt;
    logic                  exp_we;
    logic [5:0]            exp_idx;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  exp_valid;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic                  timeout;
    logic [6:0]            fail_count;
    logic [5:0]            first_fail_idx;
    logic [31:0]           cycle_count;

    modport master (
        output start, mem_we, mem_addr, mem_wdata, halt,
               exp_we, exp_idx, exp_data, exp_valid,
        input  busy, done, pass, timeout, fail_count, first_fail_idx, cycle_count
    );

    modport slave (
        input  start, mem_we, mem_addr, mem_wdata, halt,
               exp_we, exp_idx, exp_data, exp_valid,
        output busy, done, pass, timeout, fail_count, first_fail_idx, cycle_count
    );
endinterface

// File: rtl/run_monitor.sv
// Snoops CPU data-memory writes into a shadow window during a run, then compares
// the window against a loadable expected table one index per cycle.
module run_monitor #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_CHECKS     = 10,
    parameter int BASE_ADDR      = 4,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic         clk,
    input  logic         rst,
    run_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] BASE_EXT     = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0] NUM_EXT      = (ADDR_WIDTH+1)'(NUM_CHECKS);
    localparam logic [6:0]          NUM_IDX      = 7'(NUM_CHECKS);
    localparam logic [5:0]          LAST_IDX     = 6'(NUM_CHECKS - 1);
    localparam logic [31:0]         TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] exp_tab [64];
    logic [DATA_WIDTH-1:0] shadow  [64];
    logic [63:0]           exp_vld;
    logic [63:0]           written;
    logic [5:0]            chk_idx;
    logic                  timeout_r;
    logic [6:0]            fail_cnt;
    logic [5:0]            first_fail;
    logic [31:0]           cyc_cnt;

    logic [ADDR_WIDTH:0]   addr_ext, win_off;
    logic                  in_window, timeout_hit, exp_load, idx_fail;
    logic                  busy, done, pass;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign addr_ext    = {1'b0, bus.mem_addr};
    assign win_off     = addr_ext - BASE_EXT;
    assign in_window   = (addr_ext >= BASE_EXT) && (win_off < NUM_EXT);
    assign timeout_hit = (cyc_cnt == TIMEOUT_LAST);
    assign exp_load    = bus.exp_we && ({1'b0, bus.exp_idx} < NUM_IDX) &&
                         ((state == IDLE) || (state == DONE));
    assign idx_fail    = exp_vld[chk_idx] &&
                         (!written[chk_idx] || (shadow[chk_idx] != exp_tab[chk_idx]));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state)
            IDLE:  if (bus.start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (bus.halt || timeout_hit) state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (chk_idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (fail_cnt == 7'd0) && !timeout_r;
                if (bus.start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Expected data is only meaningful where exp_vld is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (exp_load) exp_tab[bus.exp_idx] <= bus.exp_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_vld    <= '0;
            written    <= '0;
            for (int i = 0; i < 64; i++) shadow[i] <= '0;
            chk_idx    <= '0;
            timeout_r  <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            cyc_cnt    <= '0;
        end else begin
            if (exp_load) exp_vld[bus.exp_idx] <= bus.exp_valid;
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        written    <= '0;
                        for (int i = 0; i < 64; i++) shadow[i] <= '0;
                        chk_idx    <= '0;
                        timeout_r  <= 1'b0;
                        fail_cnt   <= '0;
                        first_fail <= '0;
                        cyc_cnt    <= '0;
                    end
                end
                RUN: begin
                    cyc_cnt <= sat_inc(cyc_cnt);
                    // Capture also happens in the exit cycle; halt has priority over timeout.
                    if (bus.mem_we && in_window) begin
                        shadow[win_off[5:0]]  <= bus.mem_wdata;
                        written[win_off[5:0]] <= 1'b1;
                    end
                    if (!bus.halt && timeout_hit) timeout_r <= 1'b1;
                end
                CHECK: begin
                    if (idx_fail) begin
                        fail_cnt <= fail_cnt + 7'd1;
                        if (fail_cnt == 7'd0) first_fail <= chk_idx;
                    end
                    chk_idx <= (chk_idx == LAST_IDX) ? 6'd0 : chk_idx + 6'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy           = busy;
    assign bus.done           = done;
    assign bus.pass           = pass;
    assign bus.timeout        = timeout_r;
    assign bus.fail_count     = fail_cnt;
    assign bus.first_fail_idx = first_fail;
    assign bus.cycle_count    = cyc_cnt;
endmodule

// File: tb/tb_run_monitor.sv
// Scenario bench for run_monitor: directed runs plus randomized runs scored
// against a run-level reference model of the window and expected table.
module tb_run_monitor;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 10;
    localparam int BA = 4;
    localparam int TO = 500;

    logic clk = 1'b0;
    logic rst = 1'b0;

    run_monitor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    run_monitor #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHECKS(NC),
        .BASE_ADDR(BA), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_exp_data  [NC];
    logic          m_exp_valid [NC];
    logic          wr_en   [TO+2];
    logic [AW-1:0] wr_addr [TO+2];
    logic [DW-1:0] wr_data [TO+2];

    int   e_fail, e_first, e_cycles;
    logic e_timeout, e_pass;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.mem_we = 0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.halt = 0;
        bus.exp_we = 0; bus.exp_idx = '0; bus.exp_data = '0; bus.exp_valid = 0;
    endtask

    task automatic clear_writes();
        for (int k = 0; k < TO + 2; k++) begin
            wr_en[k] = 0; wr_addr[k] = '0; wr_data[k] = '0;
        end
    endtask

    task automatic add_write(input int cyc, input int addr, input logic [DW-1:0] d);
        wr_en[cyc] = 1; wr_addr[cyc] = AW'(addr); wr_data[cyc] = d;
    endtask

    task automatic load_entry(input int idx, input logic [DW-1:0] d, input bit v);
        bus.exp_we = 1; bus.exp_idx = 6'(idx); bus.exp_data = d; bus.exp_valid = v;
        tick();
        bus.exp_we = 0;
        if (idx < NC) begin
            m_exp_data[idx] = d; m_exp_valid[idx] = v;
        end
    endtask

    task automatic load_nominal();
        for (int i = 0; i < NC; i++) load_entry(i, DW'(32'h10 + i), 1'b1);
    endtask

    task automatic writes_matching();
        clear_writes();
        for (int i = 0; i < NC; i++) add_write(i + 1, BA + i, DW'(32'h10 + i));
    endtask

    // Result of a run: last write per in-window address, failures against valid entries.
    task automatic compute_model(input int halt_at);
        logic [DW-1:0] sh [NC];
        logic          wr [NC];
        bool_halt: begin end
        e_timeout = !(halt_at >= 1 && halt_at <= TO);
        e_cycles  = e_timeout ? TO : halt_at;
        for (int i = 0; i < NC; i++) begin sh[i] = '0; wr[i] = 0; end
        for (int k = 1; k <= e_cycles; k++)
            if (wr_en[k] && wr_addr[k] >= BA && wr_addr[k] < BA + NC) begin
                sh[wr_addr[k] - BA] = wr_data[k];
                wr[wr_addr[k] - BA] = 1;
            end
        e_fail = 0; e_first = 0;
        for (int i = 0; i < NC; i++)
            if (m_exp_valid[i] && (!wr[i] || sh[i] !== m_exp_data[i])) begin
                if (e_fail == 0) e_first = i;
                e_fail++;
            end
        e_pass = (e_fail == 0) && !e_timeout;
    endtask

    task automatic run_phase(input int halt_at, input bit junk_exp, output logic busy_seen);
        int last;
        last = (halt_at >= 1 && halt_at <= TO) ? halt_at : TO;
        bus.start = 1;
        tick();
        bus.start = 0;
        busy_seen = bus.busy;
        for (int k = 1; k <= last; k++) begin
            bus.mem_we = wr_en[k]; bus.mem_addr = wr_addr[k]; bus.mem_wdata = wr_data[k];
            bus.halt = (k == halt_at);
            bus.exp_we = junk_exp && (k == 2);
            bus.exp_idx = '0; bus.exp_data = 32'hDEAD_BEEF; bus.exp_valid = 1;
            tick();
        end
        idle_inputs();
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (bus.done !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; tick(); tick(); rst = 0;
        for (int i = 0; i < NC; i++) begin m_exp_valid[i] = 0; m_exp_data[i] = '0; end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset.busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset.done got %b want 0", bus.done); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset.pass got %b want 0", bus.pass); end
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL reset.timeout got %b want 0", bus.timeout); end
        n_tests++; if (bus.fail_count !== 7'd0) begin n_fail++; $display("FAIL reset.fail_count got %0d want 0", bus.fail_count); end
        n_tests++; if (bus.first_fail_idx !== 6'd0) begin n_fail++; $display("FAIL reset.first_fail_idx got %0d want 0", bus.first_fail_idx); end
        n_tests++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL reset.cycle_count got %0d want 0", bus.cycle_count); end
    endtask

    task automatic test_nominal();
        int cnt; logic bs;
        load_nominal(); writes_matching();
        compute_model(50); run_phase(50, 0, bs); wait_done(cnt);
        n_tests++; if (bs !== 1'b1) begin n_fail++; $display("FAIL nominal.busy_in_run got %b want 1", bs); end
        n_tests++; if (cnt !== NC) begin n_fail++; $display("FAIL nominal.check_cycles got %0d want %0d", cnt, NC); end
        n_tests++; if (bus.pass !== 1'b1 || e_pass !== 1'b1) begin n_fail++; $display("FAIL nominal.pass got %b want 1", bus.pass); end
        n_tests++; if (bus.fail_count !== 7'(e_fail)) begin n_fail++; $display("FAIL nominal.fail_count got %0d want %0d", bus.fail_count, e_fail); end
        n_tests++; if (bus.cycle_count !== 32'd50) begin n_fail++; $display("FAIL nominal.cycle_count got %0d want 50", bus.cycle_count); end
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL nominal.timeout got %b want 0", bus.timeout); end
    endtask

    task automatic test_mismatch();
        int cnt; logic bs;
        load_entry(12, 32'h55, 1'b1);
        load_nominal(); writes_matching();
        add_write(1, 4, 32'h99);
        add_write(20, 4, 32'h10);
        add_write(4, 7, 32'hFF);
        wr_en[9] = 0;
        compute_model(50); run_phase(50, 0, bs); wait_done(cnt);
        n_tests++; if (bus.fail_count !== 7'd2) begin n_fail++; $display("FAIL mismatch.fail_count got %0d want 2", bus.fail_count); end
        n_tests++; if (bus.first_fail_idx !== 6'd3) begin n_fail++; $display("FAIL mismatch.first_fail_idx got %0d want 3", bus.first_fail_idx); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL mismatch.pass got %b want 0", bus.pass); end
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mismatch.done got %b want 1", bus.done); end
    endtask

    task automatic test_timeout();
        int cnt; logic bs;
        writes_matching();
        compute_model(0); run_phase(0, 0, bs); wait_done(cnt);
        n_tests++; if (bus.timeout !== 1'b1) begin n_fail++; $display("FAIL timeout.timeout got %b want 1", bus.timeout); end
        n_tests++; if (bus.cycle_count !== 32'(TO)) begin n_fail++; $display("FAIL timeout.cycle_count got %0d want %0d", bus.cycle_count, TO); end
        n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL timeout.done got %b want 1", bus.done); end
        n_tests++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL timeout.pass got %b want 0", bus.pass); end
        n_tests++; if (bus.fail_count !== 7'(e_fail)) begin n_fail++; $display("FAIL timeout.fail_count got %0d want %0d", bus.fail_count, e_fail); end
    endtask

    task automatic test_halt_at_timeout();
        int cnt; logic bs;
        writes_matching();
        wr_en[10] = 0;
        add_write(30, 3, 32'h1234);
        add_write(31, 14, 32'h5678);
        add_write(TO, 13, 32'h19);
        compute_model(TO); run_phase(TO, 0, bs); wait_done(cnt);
        n_tests++; if (bus.timeout !== 1'b0) begin n_fail++; $display("FAIL halt_at_timeout.timeout got %b want 0", bus.timeout); end
        n_tests++; if (bus.pass !== 1'b1 || e_pass !== 1'b1) begin n_fail++; $display("FAIL halt_at_timeout.pass got %b want 1", bus.pass); end
        n_tests++; if (bus.cycle_count !== 32'(TO)) begin n_fail++; $display("FAIL halt_at_timeout.cycle_count got %0d want %0d", bus.cycle_count, TO); end
    endtask

    task automatic test_dont_care();
        int cnt; logic bs;
        load_entry(5, 32'h15, 1'b0);
        writes_matching();
        add_write(6, 9, 32'hBAD);
        compute_model(40); run_phase(40, 1, bs); wait_done(cnt);
        n_tests++; if (bus.pass !== 1'b1 || e_pass !== 1'b1) begin n_fail++; $display("FAIL dont_care.pass got %b want 1", bus.pass); end
        n_tests++; if (bus.fail_count !== 7'd0) begin n_fail++; $display("FAIL dont_care.fail_count got %0d want 0", bus.fail_count); end
    endtask

    task automatic test_reset_mid_check();
        int cnt; logic bs;
        load_nominal(); clear_writes();
        run_phase(5, 0, bs);
        tick(); tick(); tick();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < NC; i++) m_exp_valid[i] = 0;
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mid_check_rst.done got %b want 0", bus.done); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_check_rst.busy got %b want 0", bus.busy); end
        n_tests++; if (bus.fail_count !== 7'd0) begin n_fail++; $display("FAIL mid_check_rst.fail_count got %0d want 0", bus.fail_count); end
        n_tests++; if (bus.cycle_count !== 32'd0) begin n_fail++; $display("FAIL mid_check_rst.cycle_count got %0d want 0", bus.cycle_count); end
        clear_writes();
        compute_model(8); run_phase(8, 0, bs); wait_done(cnt);
        n_tests++; if (bus.pass !== e_pass) begin n_fail++; $display("FAIL table_cleared.pass got %b want %b", bus.pass, e_pass); end
        load_nominal(); writes_matching();
        compute_model(30); run_phase(30, 0, bs); wait_done(cnt);
        n_tests++; if (bus.pass !== 1'b1 || e_pass !== 1'b1) begin n_fail++; $display("FAIL clean_rerun.pass got %b want 1", bus.pass); end
        n_tests++; if (bus.cycle_count !== 32'd30) begin n_fail++; $display("FAIL clean_rerun.cycle_count got %0d want 30", bus.cycle_count); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int cnt, halt_at, a;
            logic bs;
            for (int i = 0; i < NC; i++)
                if ($urandom_range(0, 3) != 0) load_entry(i, DW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            clear_writes();
            halt_at = (it % 8 == 7) ? 0 : int'($urandom_range(1, 120));
            for (int k = 1; k <= TO; k++)
                if ($urandom_range(0, 2) == 0) begin
                    a = int'($urandom_range(0, 20));
                    add_write(k, a, DW'($urandom_range(0, 3)));
                end
            compute_model(halt_at); run_phase(halt_at, 0, bs); wait_done(cnt);
            n_tests++; if (bus.fail_count !== 7'(e_fail)) begin n_fail++; $display("FAIL random%0d.fail_count got %0d want %0d", it, bus.fail_count, e_fail); end
            n_tests++; if (bus.first_fail_idx !== 6'(e_first)) begin n_fail++; $display("FAIL random%0d.first_fail_idx got %0d want %0d", it, bus.first_fail_idx, e_first); end
            n_tests++; if (bus.timeout !== e_timeout) begin n_fail++; $display("FAIL random%0d.timeout got %b want %b", it, bus.timeout, e_timeout); end
            n_tests++; if (bus.cycle_count !== 32'(e_cycles)) begin n_fail++; $display("FAIL random%0d.cycle_count got %0d want %0d", it, bus.cycle_count, e_cycles); end
            n_tests++; if (bus.pass !== e_pass) begin n_fail++; $display("FAIL random%0d.pass got %b want %b", it, bus.pass, e_pass); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_writes();
        test_reset();
        test_nominal();
        test_mismatch();
        test_timeout();
        test_halt_at_timeout();
        test_dont_care();
        test_reset_mid_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
